// File: rtl/snoop_bus_arbiter_if.sv
// Snoop-bus bundle between the core cluster and the shared-bus arbiter.
// Latency: none; this is wiring only.
// Backpressure: none; request/grant is the only flow control.
// Ports (master = arbiter side, slave = core cluster side):
//   req_core, stall_from_core, bus_op_from_core, bus_addr_from_core,
//   bus_data_from_core, cache_hit_from_core          cores -> arbiter
//   grant, bus_op_to_core, bus_addr_to_core, bus_data_to_core,
//   cache_hit_to_core, owner_id, bus_busy, preempt_evt arbiter -> cores
interface snoop_bus_arbiter_if #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    localparam int OWNER_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0]        req_core;
    logic [NUM_CORES-1:0]        stall_from_core;
    logic [2*NUM_CORES-1:0]      bus_op_from_core;
    logic [ADDR_W*NUM_CORES-1:0] bus_addr_from_core;
    logic [DATA_W*NUM_CORES-1:0] bus_data_from_core;
    logic [NUM_CORES-1:0]        cache_hit_from_core;

    logic [NUM_CORES-1:0]        grant;
    logic [2*NUM_CORES-1:0]      bus_op_to_core;
    logic [ADDR_W-1:0]           bus_addr_to_core;
    logic [DATA_W-1:0]           bus_data_to_core;
    logic [NUM_CORES-1:0]        cache_hit_to_core;
    logic [OWNER_W-1:0]          owner_id;
    logic                        bus_busy;
    logic                        preempt_evt;

    modport master (
        input  req_core, stall_from_core, bus_op_from_core, bus_addr_from_core,
               bus_data_from_core, cache_hit_from_core,
        output grant, bus_op_to_core, bus_addr_to_core, bus_data_to_core,
               cache_hit_to_core, owner_id, bus_busy, preempt_evt
    );

    modport slave (
        output req_core, stall_from_core, bus_op_from_core, bus_addr_from_core,
               bus_data_from_core, cache_hit_from_core,
        input  grant, bus_op_to_core, bus_addr_to_core, bus_data_to_core,
               cache_hit_to_core, owner_id, bus_busy, preempt_evt
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner arbiter and MSI snoop broadcaster for NUM_CORES cached cores.
// Latency: request to grant 1 cycle; 2 dead cycles (GAP + IDLE) between tenures.
// Backpressure: an owner keeps the bus while requesting; a tenure longer than MAX_HOLD
// is force-ended, but only when the owner is not stalled mid-transaction.
// Ports: clk, reset (synchronous, active low), bus (snoop_bus_arbiter_if.master).
module snoop_bus_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_HOLD  = 64,
    parameter int OWNER_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    snoop_bus_arbiter_if.master bus
);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [OWNER_W-1:0] LAST_CORE = OWNER_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  rr_q, rr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                pe_q, pe_d;

    logic [NUM_CORES-1:0] owner_oh;
    logic [1:0]           own_op;
    logic [ADDR_W-1:0]    own_addr;
    logic [DATA_W-1:0]    own_data;
    logic                 owner_req;
    logic                 owner_stall;
    logic                 hit_others;
    logic                 preempt_due;
    logic [OWNER_W-1:0]   rr_next;
    logic                 pick_vld;
    logic [OWNER_W-1:0]   pick_idx;

    // Decode the registered owner and mux its bus slices.
    always_comb begin
        owner_oh = '0;
        own_op   = 2'b11;
        own_addr = '0;
        own_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (owner_q == OWNER_W'(i)) begin
                owner_oh[i] = 1'b1;
                own_op      = bus.bus_op_from_core[2*i +: 2];
                own_addr    = bus.bus_addr_from_core[ADDR_W*i +: ADDR_W];
                own_data    = bus.bus_data_from_core[DATA_W*i +: DATA_W];
            end
        end
    end

    assign owner_req   = |(bus.req_core & owner_oh);
    assign owner_stall = |(bus.stall_from_core & owner_oh);
    assign hit_others  = |(bus.cache_hit_from_core & ~owner_oh);
    // Explicit wrap: NUM_CORES need not be a power of two.
    assign rr_next     = (owner_q == LAST_CORE) ? '0 : owner_q + OWNER_W'(1);
    // hold_q saturates at MAX_HOLD, so >= keeps a deferred preemption armed.
    assign preempt_due = (MAX_HOLD != 0) && (hold_q >= HOLD_LAST) && !owner_stall;

    // Round-robin pick: first requester at or above rr_q, else first below it.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!pick_vld && bus.req_core[i] && (OWNER_W'(i) >= rr_q)) begin
                pick_vld = 1'b1;
                pick_idx = OWNER_W'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!pick_vld && bus.req_core[i] && (OWNER_W'(i) < rr_q)) begin
                pick_vld = 1'b1;
                pick_idx = OWNER_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        pe_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                // Release wins over a coincident preemption: no pulse then.
                if (!owner_req) begin
                    state_d = GAP;
                    rr_d    = rr_next;
                end else if (preempt_due) begin
                    state_d = GAP;
                    rr_d    = rr_next;
                    pe_d    = 1'b1;
                end
            end
            GAP: begin
                hold_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            pe_q    <= pe_d;
        end
    end

    // Broadcast outputs are driven only during a tenure; otherwise the bus is quiet.
    always_comb begin
        bus.grant             = '0;
        bus.bus_op_to_core    = '1;
        bus.bus_addr_to_core  = '0;
        bus.bus_data_to_core  = '0;
        bus.cache_hit_to_core = '0;
        if (state_q == OWN) begin
            bus.grant            = owner_oh;
            bus.bus_addr_to_core = own_addr;
            bus.bus_data_to_core = own_data;
            if (hit_others) begin
                bus.cache_hit_to_core = owner_oh;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!owner_oh[i]) begin
                    bus.bus_op_to_core[2*i +: 2] = own_op;
                end
            end
        end
    end

    assign bus.owner_id    = owner_q;
    assign bus.bus_busy    = (state_q == OWN);
    assign bus.preempt_evt = pe_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: 4-core/MAX_HOLD=8 instance driven from a vector table
// through a scoreboard queue, plus a 3-core instance with preemption disabled.
module tb_snoop_bus_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    snoop_bus_arbiter_if #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32)) bif ();
    snoop_bus_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset), .bus(bif)
    );

    snoop_bus_arbiter_if #(.NUM_CORES(3), .ADDR_W(16), .DATA_W(8)) bif3 ();
    snoop_bus_arbiter #(.NUM_CORES(3), .ADDR_W(16), .DATA_W(8), .MAX_HOLD(0)) dut3 (
        .clk(clk), .reset(reset), .bus(bif3)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [3:0]  stall;
        logic [3:0]  hit_in;
        logic [7:0]  op_in;
        logic [3:0]  grant;
        logic        busy;
        logic        pe;
        logic [1:0]  owner;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  hit;
    } vec_t;

    typedef struct {
        int   cyc;
        int   row;
        vec_t v;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Row with the bus not owned (IDLE, GAP or reset): everything quiet.
    function automatic void add_idle(logic rst_n, logic [3:0] req, logic [3:0] stall,
                                     int owner, logic pe);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.stall = stall; v.hit_in = 4'h0; v.op_in = 8'h00;
        v.grant = 4'h0; v.busy = 1'b0; v.pe = pe; v.owner = 2'(owner);
        v.op = 8'hFF; v.addr = 32'h0; v.data = 32'h0; v.hit = 4'h0;
        vecs.push_back(v);
    endfunction

    // Row observed during a tenure of 'owner'.
    function automatic void add_own(logic [3:0] req, logic [3:0] stall, int owner,
                                    logic [7:0] op_in, logic [3:0] hit_in,
                                    logic [7:0] exp_op, logic [3:0] exp_hit);
        vec_t v;
        v.rst_n = 1'b1; v.req = req; v.stall = stall; v.hit_in = hit_in; v.op_in = op_in;
        v.grant = 4'(1 << owner); v.busy = 1'b1; v.pe = 1'b0; v.owner = 2'(owner);
        v.op = exp_op; v.addr = 32'(owner) << 6; v.data = 32'hD000_0000 | 32'(owner);
        v.hit = exp_hit;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Scoreboard consumer: compares each expected row in the cycle it belongs to.
    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (bif.grant !== e.v.grant || bif.bus_busy !== e.v.busy ||
                    bif.preempt_evt !== e.v.pe || bif.owner_id !== e.v.owner ||
                    bif.bus_op_to_core !== e.v.op || bif.bus_addr_to_core !== e.v.addr ||
                    bif.bus_data_to_core !== e.v.data || bif.cache_hit_to_core !== e.v.hit) begin
                    failures++;
                    $display("FAIL row%0d: got grant=%b busy=%b pe=%b owner=%0d op=%h addr=%h data=%h hit=%b; expected grant=%b busy=%b pe=%b owner=%0d op=%h addr=%h data=%h hit=%b",
                             e.row, bif.grant, bif.bus_busy, bif.preempt_evt, bif.owner_id,
                             bif.bus_op_to_core, bif.bus_addr_to_core, bif.bus_data_to_core,
                             bif.cache_hit_to_core, e.v.grant, e.v.busy, e.v.pe, e.v.owner,
                             e.v.op, e.v.addr, e.v.data, e.v.hit);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic seen;
        reset = 1'b0;
        bif.req_core = '0; bif.stall_from_core = '0; bif.bus_op_from_core = '0;
        bif.cache_hit_from_core = '0;
        bif.bus_addr_from_core = {32'h0000_00C0, 32'h0000_0080, 32'h0000_0040, 32'h0000_0000};
        bif.bus_data_from_core = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        bif3.req_core = '0; bif3.stall_from_core = '0; bif3.bus_op_from_core = '0;
        bif3.cache_hit_from_core = '0;
        bif3.bus_addr_from_core = {16'h3333, 16'h2222, 16'h1111};
        bif3.bus_data_from_core = {8'h33, 8'h22, 8'h11};

        // Reset held with all cores requesting.
        add_idle(1'b0, 4'hF, 4'h0, 0, 1'b0);
        add_idle(1'b0, 4'hF, 4'h0, 0, 1'b0);
        // Round robin: each owner drops its request after 3 cycles of tenure.
        add_idle(1'b1, 4'hF, 4'h0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) add_own(4'hF, 4'h0, k, 8'h00, 4'h0, 8'h03 << (2*k), 4'h0);
            add_own(4'hF & ~(4'h1 << k), 4'h0, k, 8'h00, 4'h0, 8'h03 << (2*k), 4'h0);
            add_idle(1'b1, 4'hF, 4'h0, k, 1'b0);
            add_idle(1'b1, 4'hF, 4'h0, k, 1'b0);
        end
        add_own(4'hF, 4'h0, 0, 8'h00, 4'h0, 8'h03, 4'h0);
        add_own(4'h0, 4'h0, 0, 8'h00, 4'h0, 8'h03, 4'h0);
        add_idle(1'b1, 4'h0, 4'h0, 0, 1'b0);
        add_idle(1'b1, 4'h0, 4'h0, 0, 1'b0);
        add_idle(1'b1, 4'h0, 4'h0, 0, 1'b0);
        // Broadcast: core1 owns with BusRdX, other cores drive different ops.
        add_idle(1'b1, 4'b0010, 4'h0, 0, 1'b0);
        add_own(4'b0010, 4'h0, 1, 8'h49, 4'b0001, 8'hAE, 4'b0010);
        add_own(4'b0010, 4'h0, 1, 8'h49, 4'b0010, 8'hAE, 4'b0000);
        add_own(4'b0010, 4'h0, 1, 8'h49, 4'b1100, 8'hAE, 4'b0010);
        add_own(4'b0000, 4'h0, 1, 8'h49, 4'b0000, 8'hAE, 4'b0000);
        add_idle(1'b1, 4'h0, 4'h0, 1, 1'b0);
        add_idle(1'b1, 4'h0, 4'h0, 1, 1'b0);
        // Preemption after 8 cycles; core1 waiting gets the bus 2 cycles later.
        add_idle(1'b1, 4'b0011, 4'h0, 1, 1'b0);
        for (int j = 0; j < 8; j++) add_own(4'b0011, 4'h0, 0, 8'h00, 4'h0, 8'h03, 4'h0);
        add_idle(1'b1, 4'b0011, 4'h0, 0, 1'b1);
        add_idle(1'b1, 4'b0011, 4'h0, 0, 1'b0);
        add_own(4'b0000, 4'h0, 1, 8'h00, 4'h0, 8'h0C, 4'h0);
        add_idle(1'b1, 4'h0, 4'h0, 1, 1'b0);
        add_idle(1'b1, 4'h0, 4'h0, 1, 1'b0);
        // Deferred preemption: stall held for 12 cycles.
        add_idle(1'b1, 4'b0001, 4'b0001, 1, 1'b0);
        for (int j = 0; j < 12; j++) add_own(4'b0001, 4'b0001, 0, 8'h00, 4'h0, 8'h03, 4'h0);
        add_own(4'b0001, 4'b0000, 0, 8'h00, 4'h0, 8'h03, 4'h0);
        add_idle(1'b1, 4'b0001, 4'h0, 0, 1'b1);
        add_idle(1'b1, 4'h0, 4'h0, 0, 1'b0);
        // Release in the same cycle preemption falls due: no pulse.
        add_idle(1'b1, 4'b0001, 4'h0, 0, 1'b0);
        for (int j = 0; j < 7; j++) add_own(4'b0001, 4'h0, 0, 8'h00, 4'h0, 8'h03, 4'h0);
        add_own(4'b0000, 4'h0, 0, 8'h00, 4'h0, 8'h03, 4'h0);
        add_idle(1'b1, 4'h0, 4'h0, 0, 1'b0);
        add_idle(1'b1, 4'h0, 4'h0, 0, 1'b0);
        // Short core1 tenure leaves the pointer at core2.
        add_idle(1'b1, 4'b0010, 4'h0, 0, 1'b0);
        add_own(4'b0000, 4'h0, 1, 8'h00, 4'h0, 8'h0C, 4'h0);
        add_idle(1'b1, 4'h0, 4'h0, 1, 1'b0);
        add_idle(1'b1, 4'h0, 4'h0, 1, 1'b0);
        // Reset mid-tenure of core2; afterwards core1 wins from pointer 0.
        add_idle(1'b1, 4'b0100, 4'h0, 1, 1'b0);
        add_own(4'b0100, 4'h0, 2, 8'h00, 4'h0, 8'h30, 4'h0);
        add_own(4'b0110, 4'h0, 2, 8'h00, 4'h0, 8'h30, 4'h0);
        vecs[vecs.size()-1].rst_n = 1'b0;
        add_idle(1'b1, 4'b0110, 4'h0, 0, 1'b0);
        add_own(4'b0000, 4'h0, 1, 8'h00, 4'h0, 8'h0C, 4'h0);
        add_idle(1'b1, 4'h0, 4'h0, 1, 1'b0);
        add_idle(1'b1, 4'h0, 4'h0, 1, 1'b0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            reset                   = vecs[i].rst_n;
            bif.req_core            = vecs[i].req;
            bif.stall_from_core     = vecs[i].stall;
            bif.bus_op_from_core    = vecs[i].op_in;
            bif.cache_hit_from_core = vecs[i].hit_in;
            sb.push_back('{cyc: cyc, row: i, v: vecs[i]});
        end
        tick();
        reset = 1'b1;
        bif.req_core = '0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        // 3 cores, preemption disabled: long hold, then wrap of the pointer past core2.
        tick(); bif3.req_core = 3'b100;
        tick();
        @(negedge clk);
        chk("n3_grant_core2", 32'(bif3.grant), 32'b100);
        chk("n3_owner_core2", 32'(bif3.owner_id), 32'd2);
        chk("n3_op_broadcast", 32'(bif3.bus_op_to_core), 32'b11_00_00);
        chk("n3_addr_broadcast", 32'(bif3.bus_addr_to_core), 32'h3333);
        seen = 1'b0;
        repeat (80) begin
            tick();
            @(negedge clk);
            if (bif3.preempt_evt !== 1'b0 || bif3.grant !== 3'b100) seen = 1'b1;
        end
        chk("n3_no_preempt_80cyc", 32'(seen), 32'd0);
        tick(); bif3.req_core = 3'b000;
        tick();
        @(negedge clk);
        chk("n3_gap_grant", 32'(bif3.grant), 32'd0);
        tick(); bif3.req_core = 3'b011;
        tick();
        @(negedge clk);
        chk("n3_wrap_core0", 32'(bif3.grant), 32'b001);
        tick(); bif3.req_core = 3'b000;
        tick();
        tick(); bif3.req_core = 3'b101;
        tick();
        @(negedge clk);
        chk("n3_rr_core2", 32'(bif3.grant), 32'b100);
        chk("n3_owner_rr", 32'(bif3.owner_id), 32'd2);
        tick(); bif3.req_core = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
Parametrised shared-bus arbiter and snoop broadcaster for N cached RISC-V cores. It collects each core's req_core, grants the MSI snoop bus to one core at a time in round-robin order, and broadcasts the owner's bus operation, address and data to all other cores. It also aggregates the other cores' cache_hit signals back to the owner and force-releases a core that holds the bus too long. It replaces the fixed two-core grant logic at the top level of the multicore cache system.

Parameters:
NUM_CORES, 2, number of cores on the bus (2..16)
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
MAX_HOLD, 64, maximum cycles of one tenure before preemption; 0 disables preemption
OWNER_W, max(1,$clog2(NUM_CORES)), width of the owner index (derived, do not override)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
req_core  input  NUM_CORES  per-core bus request
stall_from_core  input  NUM_CORES  per-core stall; high means a transaction is in progress
bus_op_from_core  input  2*NUM_CORES  packed per-core op: 00 BusRd, 01 BusUpgr, 10 BusRdX, 11 BusNoN
bus_addr_from_core  input  ADDR_W*NUM_CORES  packed per-core bus address
bus_data_from_core  input  DATA_W*NUM_CORES  packed per-core bus data
cache_hit_from_core  input  NUM_CORES  per-core snoop hit
grant  output  NUM_CORES  one-hot grant, or all zero
bus_op_to_core  output  2*NUM_CORES  per-core snoop op; owner and idle cores get 11
bus_addr_to_core  output  ADDR_W  broadcast address
bus_data_to_core  output  DATA_W  broadcast data
cache_hit_to_core  output  NUM_CORES  per-core aggregated hit; only the owner's bit can be set
owner_id  output  OWNER_W  index of the current owner
bus_busy  output  1  high in OWN state
preempt_evt  output  1  one-cycle pulse when a tenure is force-ended

Behaviour:
- Reset: reset is synchronous and active-low. While reset==0 at a rising clk edge, the block enters state IDLE with rr_ptr=0, hold_cnt=0, owner_id=0, grant=0, bus_busy=0 and preempt_evt=0. All bus_op_to_core fields are 11, bus_addr_to_core and bus_data_to_core are 0, and cache_hit_to_core is 0. Reset asserted mid-tenure drops grant at that edge, with no completion.
- States: IDLE, OWN, GAP.
- IDLE:
  - If req_core is nonzero, select the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_CORES-1, 0, ...).
  - Register that bit as owner_id, then OWN. grant[owner] is high on the next cycle, so request-to-grant latency is 1 cycle.
  - If req_core is zero, stay in IDLE.
- OWN:
  - grant = 1<<owner_id and bus_busy=1.
  - Broadcast outputs are combinational muxes from the registered owner_id:
    - bus_addr_to_core and bus_data_to_core come from the owner's slices.
    - bus_op_to_core[i] = owner's op for every i != owner; bus_op_to_core[owner] = 11.
  - cache_hit_to_core[owner] = OR of cache_hit_from_core[j] for all j != owner. All other bits are 0.
  - hold_cnt increments each OWN cycle and saturates at MAX_HOLD.
- Normal release: if req_core[owner]==0, go to GAP and set rr_ptr = (owner_id+1) mod NUM_CORES. The wrap is explicit (NUM_CORES need not be a power of 2).
- Preemption: applies only when MAX_HOLD != 0, hold_cnt == MAX_HOLD-1 and stall_from_core[owner]==0.
  - Go to GAP, set rr_ptr = owner+1 mod N, and pulse preempt_evt for exactly the cycle after the transition.
  - If stall_from_core[owner]==1, preemption is deferred until stall drops. A bus transaction is never cut.
- Simultaneous events: if release and preemption occur in the same cycle, treat it as a normal release with no preempt_evt.
- GAP: exactly one cycle with grant=0, bus_busy=0 and all ops 11. Clear hold_cnt, then go to IDLE. Minimum spacing between tenures is therefore 2 dead cycles (GAP + IDLE arbitration).
- Requests that drop while in IDLE before being granted are simply ignored. There is no latching of requests.
- A single requester that re-requests immediately is regranted after GAP+IDLE. Round-robin still lets it win, because no other request is pending.
- Invariants: grant is never multi-hot, and grant is never high outside OWN.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_core=2'b11 -> grant=00, bus_op_to_core=4'b1111 and preempt_evt=0 throughout.
- Round-robin, NUM_CORES=4: req_core=4'b1111 held, each owner drops req for 1 cycle after 3 cycles of tenure -> grant sequence 0001, 0010, 0100, 1000, 0001, with 2 dead cycles between tenures.
- Broadcast: core1 owns with op=10 (BusRdX) and addr=0x0000_0040, and core0 drives cache_hit_from_core=1 -> bus_op_to_core core0=10, core1=11; bus_addr_to_core=0x40; cache_hit_to_core=2'b10.
- Preemption, MAX_HOLD=8: core0 holds req with stall=0 -> grant drops after 8 OWN cycles, preempt_evt pulses once, and core1 (also requesting) is granted 2 cycles later.
- Deferred preemption, MAX_HOLD=8: core0 holds req with stall=1 through cycle 12 -> grant stays 01 until stall drops, then GAP and preempt_evt=1.
- Reset mid-tenure: reset=0 while core2 owns -> grant=0 at that edge and rr_ptr=0; after reset=1 with req=4'b0110, core1 is granted first.
